// File: rtl/run_stim_gen_if.sv
// Command channel for run_stim_gen: a {bit, length} run offered over valid/ready.
interface run_stim_gen_if #(
   parameter int LEN_W = 4
);
   logic             cmd_valid;
   logic             cmd_bit;
   logic [LEN_W-1:0] cmd_len;
   logic             cmd_ready;

   modport master (output cmd_valid, output cmd_bit, output cmd_len, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_bit, input cmd_len, output cmd_ready);
endinterface

// File: rtl/run_stim_gen.sv
// Serial run transmitter for the lab11 run detector: emits queued {bit, length} runs
// gaplessly on w, one bit per step, with z_exp = 1 when the last two emitted bits match.
module run_stim_gen #(
   parameter int LEN_W = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               clr,
   input  logic               step,
   run_stim_gen_if.slave      cmd,
   output logic               w,
   output logic               w_valid,
   output logic               z_exp,
   output logic               busy
);
   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic             act_bit;
   logic [LEN_W-1:0] remaining;
   logic             pend_full;
   logic             pend_bit;
   logic [LEN_W-1:0] pend_len;
   logic             hist_ok;

   logic accept;
   logic cmd_nonzero;
   logic emit;
   logic last_bit;

   assign cmd.cmd_ready = ~pend_full;
   assign accept        = cmd.cmd_valid & ~pend_full;
   assign cmd_nonzero   = (cmd.cmd_len != '0);
   assign emit          = (state == RUN) & step;
   assign last_bit      = emit & (remaining == LEN_W'(1));
   assign busy          = (state == RUN) | pend_full;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         act_bit   <= 1'b0;
         remaining <= '0;
         pend_full <= 1'b0;
         pend_bit  <= 1'b0;
         pend_len  <= '0;
         hist_ok   <= 1'b0;
         w         <= 1'b0;
         w_valid   <= 1'b0;
         z_exp     <= 1'b0;
      end else begin
         w_valid <= emit;
         if (emit) begin
            w <= act_bit;
            if (remaining != '0)
               remaining <= remaining - LEN_W'(1);
         end

         // Loads below override the decrement above; zero-length commands are swallowed.
         if (state == IDLE) begin
            if (accept && cmd_nonzero) begin
               state     <= RUN;
               act_bit   <= cmd.cmd_bit;
               remaining <= cmd.cmd_len;
            end
         end else if (last_bit) begin
            if (pend_full) begin
               act_bit   <= pend_bit;
               remaining <= pend_len;
               pend_full <= 1'b0;
            end else if (accept && cmd_nonzero) begin
               act_bit   <= cmd.cmd_bit;
               remaining <= cmd.cmd_len;
            end else begin
               state <= IDLE;
            end
         end else if (accept && cmd_nonzero) begin
            pend_full <= 1'b1;
            pend_bit  <= cmd.cmd_bit;
            pend_len  <= cmd.cmd_len;
         end

         // w still holds the previously emitted bit here, so it serves as history.
         if (emit) begin
            z_exp   <= ~clr & hist_ok & (act_bit == w);
            hist_ok <= 1'b1;
         end else if (clr) begin
            z_exp   <= 1'b0;
            hist_ok <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_run_stim_gen.sv
// Directed bench for run_stim_gen: linear stimulus, hand-computed expectations.
module tb_run_stim_gen;
   localparam int LEN_W = 4;

   logic clk;
   logic reset_n;
   logic clr;
   logic step;
   logic w;
   logic w_valid;
   logic z_exp;
   logic busy;

   int errors = 0;
   int checks = 0;

   run_stim_gen_if #(.LEN_W(LEN_W)) cif ();

   run_stim_gen #(.LEN_W(LEN_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (clr),
      .step    (step),
      .cmd     (cif.slave),
      .w       (w),
      .w_valid (w_valid),
      .z_exp   (z_exp),
      .busy    (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic obs, input logic expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
      end
   endtask

   task automatic offer(input logic b, input logic [LEN_W-1:0] len);
      cif.cmd_valid = 1'b1;
      cif.cmd_bit   = b;
      cif.cmd_len   = len;
   endtask

   task automatic chk_bit(input string tag, input logic ew, input logic ez);
      chk({tag, ".w_valid"}, w_valid, 1'b1);
      chk({tag, ".w"}, w, ew);
      chk({tag, ".z_exp"}, z_exp, ez);
      $display("%s: w=%b w_valid=%b z_exp=%b busy=%b", tag, w, w_valid, z_exp, busy);
   endtask

   task automatic clear_hist();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   initial begin
      reset_n       = 1'b0;
      clr           = 1'b0;
      step          = 1'b0;
      cif.cmd_valid = 1'b0;
      cif.cmd_bit   = 1'b0;
      cif.cmd_len   = '0;
      tick();
      tick();
      chk("rst.w", w, 1'b0);
      chk("rst.w_valid", w_valid, 1'b0);
      chk("rst.z_exp", z_exp, 1'b0);
      chk("rst.busy", busy, 1'b0);
      chk("rst.ready", cif.cmd_ready, 1'b1);
      reset_n = 1'b1;
      tick();

      // Single run {0,3}
      offer(1'b0, 4'd3);
      tick();
      chk("t2.busy_after_accept", busy, 1'b1);
      chk("t2.no_bit_on_accept", w_valid, 1'b0);
      cif.cmd_valid = 1'b0;
      step = 1'b1;
      tick(); chk_bit("t2.b0", 1'b0, 1'b0);
      tick(); chk_bit("t2.b1", 1'b0, 1'b1);
      tick(); chk_bit("t2.b2", 1'b0, 1'b1);
      chk("t2.busy_end", busy, 1'b0);
      tick();
      chk("t2.idle_w_valid", w_valid, 1'b0);
      step = 1'b0;

      // {0,1} active, {1,2} pending, then gapless emission
      clear_hist();
      offer(1'b0, 4'd1);
      tick();
      offer(1'b1, 4'd2);
      tick();
      chk("t3.ready_pend_full", cif.cmd_ready, 1'b0);
      chk("t3.busy_pend", busy, 1'b1);
      cif.cmd_valid = 1'b0;
      step = 1'b1;
      tick(); chk_bit("t3.b0", 1'b0, 1'b0);
      chk("t3.ready_freed", cif.cmd_ready, 1'b1);
      tick(); chk_bit("t3.b1", 1'b1, 1'b0);
      tick(); chk_bit("t3.b2", 1'b1, 1'b1);
      chk("t3.busy_end", busy, 1'b0);
      step = 1'b0;

      // {1,4} with step pattern 1,0,0,1,1,1
      clear_hist();
      offer(1'b1, 4'd4);
      tick();
      cif.cmd_valid = 1'b0;
      step = 1'b1; tick(); chk_bit("t4.b0", 1'b1, 1'b0);
      step = 1'b0; tick();
      chk("t4.hold1.w_valid", w_valid, 1'b0);
      chk("t4.hold1.w", w, 1'b1);
      tick();
      chk("t4.hold2.w_valid", w_valid, 1'b0);
      chk("t4.hold2.w", w, 1'b1);
      chk("t4.hold2.busy", busy, 1'b1);
      step = 1'b1; tick(); chk_bit("t4.b1", 1'b1, 1'b1);
      tick(); chk_bit("t4.b2", 1'b1, 1'b1);
      tick(); chk_bit("t4.b3", 1'b1, 1'b1);
      chk("t4.busy_end", busy, 1'b0);
      step = 1'b0;

      // {1,2}, clr on 2nd bit while {1,1} is accepted on the same last-bit edge
      clear_hist();
      offer(1'b1, 4'd2);
      tick();
      cif.cmd_valid = 1'b0;
      step = 1'b1;
      tick(); chk_bit("t5.b0", 1'b1, 1'b0);
      clr = 1'b1;
      offer(1'b1, 4'd1);
      tick(); chk_bit("t5.b1_clr", 1'b1, 1'b0);
      chk("t5.busy_direct_load", busy, 1'b1);
      clr = 1'b0;
      cif.cmd_valid = 1'b0;
      tick(); chk_bit("t5.b2", 1'b1, 1'b1);
      chk("t5.busy_end", busy, 1'b0);
      step = 1'b0;

      // Null command, then {1,1}
      clear_hist();
      step = 1'b1;
      offer(1'b0, 4'd0);
      chk("t6.ready_null", cif.cmd_ready, 1'b1);
      tick();
      cif.cmd_valid = 1'b0;
      chk("t6.null_busy", busy, 1'b0);
      chk("t6.null_w_valid", w_valid, 1'b0);
      tick();
      chk("t6.null_w_valid2", w_valid, 1'b0);
      offer(1'b1, 4'd1);
      tick();
      cif.cmd_valid = 1'b0;
      tick(); chk_bit("t6.b0", 1'b1, 1'b0);
      chk("t6.busy_end", busy, 1'b0);
      step = 1'b0;

      // Async reset in the middle of a run
      clear_hist();
      offer(1'b1, 4'd5);
      tick();
      cif.cmd_valid = 1'b0;
      step = 1'b1;
      tick(); chk_bit("t1.b0", 1'b1, 1'b0);
      tick(); chk_bit("t1.b1", 1'b1, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      chk("t1.async.w", w, 1'b0);
      chk("t1.async.w_valid", w_valid, 1'b0);
      chk("t1.async.z_exp", z_exp, 1'b0);
      chk("t1.async.busy", busy, 1'b0);
      chk("t1.async.ready", cif.cmd_ready, 1'b1);
      tick();
      reset_n = 1'b1;
      tick();
      chk("t1.post.w_valid", w_valid, 1'b0);
      chk("t1.post.busy", busy, 1'b0);
      step = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
